// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter: funnels NM upstream AXI3 masters onto a single downstream
// master port. Read and write paths arbitrate independently, one transaction each.
// Master index: 2 = icache, 1 = dcache, 0 = uncache.
// Build option: define AXI_ARB_ROUND_ROBIN_EN for per-path round-robin arbitration;
// otherwise fixed priority dcache > icache > uncache. NM must be at least 3.
module axi_master_arbiter #(
    parameter int unsigned NM  = 3,
    parameter int unsigned IDW = 4
) (
    input  logic              clk,
    input  logic              resetn,
    // upstream read address / data
    input  logic [NM*IDW-1:0] s_arid,
    input  logic [NM*32-1:0]  s_araddr,
    input  logic [NM*8-1:0]   s_arlen,
    input  logic [NM*3-1:0]   s_arsize,
    input  logic [NM*2-1:0]   s_arburst,
    input  logic [NM*4-1:0]   s_arcache,
    input  logic [NM*3-1:0]   s_arprot,
    input  logic [NM-1:0]     s_arvalid,
    output logic [NM-1:0]     s_arready,
    output logic [NM-1:0]     s_rvalid,
    input  logic [NM-1:0]     s_rready,
    output logic [31:0]       s_rdata,
    output logic [IDW-1:0]    s_rid,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    // upstream write address / data / response
    input  logic [NM*IDW-1:0] s_awid,
    input  logic [NM*32-1:0]  s_awaddr,
    input  logic [NM*8-1:0]   s_awlen,
    input  logic [NM*3-1:0]   s_awsize,
    input  logic [NM*2-1:0]   s_awburst,
    input  logic [NM*4-1:0]   s_awcache,
    input  logic [NM*3-1:0]   s_awprot,
    input  logic [NM-1:0]     s_awvalid,
    output logic [NM-1:0]     s_awready,
    input  logic [NM*32-1:0]  s_wdata,
    input  logic [NM*4-1:0]   s_wstrb,
    input  logic [NM-1:0]     s_wlast,
    input  logic [NM-1:0]     s_wvalid,
    output logic [NM-1:0]     s_wready,
    output logic [NM-1:0]     s_bvalid,
    input  logic [NM-1:0]     s_bready,
    output logic [IDW-1:0]    s_bid,
    output logic [1:0]        s_bresp,
    // downstream AXI3 master port
    output logic [IDW-1:0]    m_arid,
    output logic [31:0]       m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic [1:0]        m_arlock,
    output logic [3:0]        m_arcache,
    output logic [2:0]        m_arprot,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [IDW-1:0]    m_rid,
    input  logic [31:0]       m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic [IDW-1:0]    m_awid,
    output logic [31:0]       m_awaddr,
    output logic [7:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic [1:0]        m_awburst,
    output logic [1:0]        m_awlock,
    output logic [3:0]        m_awcache,
    output logic [2:0]        m_awprot,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [IDW-1:0]    m_wid,
    output logic [31:0]       m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [IDW-1:0]    m_bid,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;

    r_state_e          r_state;
    w_state_e          w_state;
    logic [NM-1:0]     rgrant, wgrant;
    logic [NM-1:0]     r_pick, w_pick;
    logic [IDW-1:0]    w_pick_id;
    logic [IDW-1:0]    wid_reg;

`ifdef AXI_ARB_ROUND_ROBIN_EN
    localparam int unsigned PW = (NM > 1) ? $clog2(NM) : 1;
    logic [PW-1:0] r_ptr, w_ptr;

    // First requester at or above the pointer wins, else wrap to the lowest index.
    function automatic logic [NM-1:0] arb(input logic [NM-1:0] req, input logic [PW-1:0] ptr);
        logic [NM-1:0] g;
        g = '0;
        for (int i = 0; i < NM; i++)
            if (g == '0 && req[i] && i >= int'(ptr)) g[i] = 1'b1;
        for (int i = 0; i < NM; i++)
            if (g == '0 && req[i]) g[i] = 1'b1;
        return g;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [NM-1:0] g);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < NM; i++)
            if (g[i]) p = (i == int'(NM) - 1) ? '0 : PW'(i + 1);
        return p;
    endfunction

    assign r_pick = arb(s_arvalid, r_ptr);
    assign w_pick = arb(s_awvalid, w_ptr);
`else
    // dcache first (lowest miss latency matters most), then icache, then uncache.
    function automatic logic [NM-1:0] arb(input logic [NM-1:0] req);
        logic [NM-1:0] g;
        g = '0;
        if (req[1])      g[1] = 1'b1;
        else if (req[2]) g[2] = 1'b1;
        else if (req[0]) g[0] = 1'b1;
        else
            for (int i = 3; i < NM; i++)
                if (g == '0 && req[i]) g[i] = 1'b1;
        return g;
    endfunction

    assign r_pick = arb(s_arvalid);
    assign w_pick = arb(s_awvalid);
`endif

    // ID of the write winner, captured at grant so m_wid needs no live awid.
    always_comb begin
        w_pick_id = '0;
        for (int i = 0; i < NM; i++)
            if (w_pick[i]) w_pick_id = s_awid[i*IDW +: IDW];
    end

    // Read path FSM: grant only changes in R_IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= R_IDLE;
            rgrant  <= '0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
            r_ptr   <= '0;
`endif
        end else begin
            case (r_state)
                R_IDLE: if (|s_arvalid) begin
                    rgrant  <= r_pick;
`ifdef AXI_ARB_ROUND_ROBIN_EN
                    r_ptr   <= next_ptr(r_pick);
`endif
                    r_state <= R_ADDR;
                end
                R_ADDR: if (m_arready) r_state <= R_DATA;
                R_DATA: if (m_rvalid && m_rready && m_rlast) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Write path FSM: grant and write ID only change in W_IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state <= W_IDLE;
            wgrant  <= '0;
            wid_reg <= '0;
`ifdef AXI_ARB_ROUND_ROBIN_EN
            w_ptr   <= '0;
`endif
        end else begin
            case (w_state)
                W_IDLE: if (|s_awvalid) begin
                    wgrant  <= w_pick;
                    wid_reg <= w_pick_id;
`ifdef AXI_ARB_ROUND_ROBIN_EN
                    w_ptr   <= next_ptr(w_pick);
`endif
                    w_state <= W_ADDR;
                end
                W_ADDR: if (m_awready) w_state <= W_DATA;
                W_DATA: if (m_wvalid && m_wready && m_wlast) w_state <= W_RESP;
                W_RESP: if (m_bvalid && m_bready) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read channel steering: fields muxed by grant, handshakes gated by state.
    always_comb begin
        m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0;
        m_arburst = '0; m_arcache = '0; m_arprot = '0;
        for (int i = 0; i < NM; i++)
            if (rgrant[i]) begin
                m_arid    = s_arid[i*IDW +: IDW];
                m_araddr  = s_araddr[i*32 +: 32];
                m_arlen   = s_arlen[i*8 +: 8];
                m_arsize  = s_arsize[i*3 +: 3];
                m_arburst = s_arburst[i*2 +: 2];
                m_arcache = s_arcache[i*4 +: 4];
                m_arprot  = s_arprot[i*3 +: 3];
            end
        m_arvalid = (r_state == R_ADDR);
        s_arready = (r_state == R_ADDR && m_arready) ? rgrant : '0;
        s_rvalid  = (r_state == R_DATA && m_rvalid) ? rgrant : '0;
        m_rready  = (r_state == R_DATA) && |(s_rready & rgrant);
    end

    // Write channel steering: AW and W fields muxed by grant, B handshake gated.
    always_comb begin
        m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0;
        m_awburst = '0; m_awcache = '0; m_awprot = '0;
        m_wdata = '0; m_wstrb = '0; m_wlast = 1'b0;
        for (int i = 0; i < NM; i++)
            if (wgrant[i]) begin
                m_awid    = s_awid[i*IDW +: IDW];
                m_awaddr  = s_awaddr[i*32 +: 32];
                m_awlen   = s_awlen[i*8 +: 8];
                m_awsize  = s_awsize[i*3 +: 3];
                m_awburst = s_awburst[i*2 +: 2];
                m_awcache = s_awcache[i*4 +: 4];
                m_awprot  = s_awprot[i*3 +: 3];
                m_wdata   = s_wdata[i*32 +: 32];
                m_wstrb   = s_wstrb[i*4 +: 4];
                m_wlast   = s_wlast[i];
            end
        m_awvalid = (w_state == W_ADDR);
        s_awready = (w_state == W_ADDR && m_awready) ? wgrant : '0;
        m_wvalid  = (w_state == W_DATA) && |(s_wvalid & wgrant);
        s_wready  = (w_state == W_DATA && m_wready) ? wgrant : '0;
        s_bvalid  = (w_state == W_RESP && m_bvalid) ? wgrant : '0;
        m_bready  = (w_state == W_RESP) && |(s_bready & wgrant);
    end

    assign m_wid    = wid_reg;
    assign m_arlock = 2'b00;
    assign m_awlock = 2'b00;
    assign s_rdata  = m_rdata;
    assign s_rid    = m_rid;
    assign s_rresp  = m_rresp;
    assign s_rlast  = m_rlast;
    assign s_bid    = m_bid;
    assign s_bresp  = m_bresp;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed bench for axi_master_arbiter: a per-cycle read-path vector table plus
// hand sequences for all-master contention, concurrent read/write and mid-burst reset.
module tb_axi_master_arbiter;
    localparam int NM  = 3;
    localparam int IDW = 4;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    logic [NM*IDW-1:0] s_arid, s_awid;
    logic [NM*32-1:0]  s_araddr, s_awaddr, s_wdata;
    logic [NM*8-1:0]   s_arlen, s_awlen;
    logic [NM*3-1:0]   s_arsize, s_awsize, s_arprot, s_awprot;
    logic [NM*2-1:0]   s_arburst, s_awburst;
    logic [NM*4-1:0]   s_arcache, s_awcache, s_wstrb;
    logic [NM-1:0]     s_arvalid, s_arready, s_rvalid, s_rready;
    logic [NM-1:0]     s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0]       s_rdata;
    logic [IDW-1:0]    s_rid, s_bid;
    logic [1:0]        s_rresp, s_bresp;
    logic              s_rlast;

    logic [IDW-1:0]    m_arid, m_rid, m_awid, m_wid, m_bid;
    logic [31:0]       m_araddr, m_rdata, m_awaddr, m_wdata;
    logic [7:0]        m_arlen, m_awlen;
    logic [2:0]        m_arsize, m_arprot, m_awsize, m_awprot;
    logic [1:0]        m_arburst, m_arlock, m_awburst, m_awlock, m_rresp, m_bresp;
    logic [3:0]        m_arcache, m_awcache, m_wstrb;
    logic              m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic              m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

    int total = 0;
    int bad   = 0;

    axi_master_arbiter #(.NM(NM), .IDW(IDW)) dut (
        .clk(clk), .resetn(resetn),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rid(s_rid),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awcache(s_awcache), .s_awprot(s_awprot),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache),
        .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache),
        .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  arv;
        logic        arrdy;
        logic        rv;
        logic        rl;
        logic [2:0]  rrdy;
        logic        e_arv;
        logic [2:0]  e_arrdy;
        logic [2:0]  e_rv;
        logic        e_rrdy;
        logic        ck_addr;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [2:0] arv, input logic arrdy, input logic rv,
                                input logic rl, input logic [2:0] rrdy, input logic e_arv,
                                input logic [2:0] e_arrdy, input logic [2:0] e_rv,
                                input logic e_rrdy, input logic ck, input logic [31:0] ea);
        vec_t v;
        v.arv = arv; v.arrdy = arrdy; v.rv = rv; v.rl = rl; v.rrdy = rrdy;
        v.e_arv = e_arv; v.e_arrdy = e_arrdy; v.e_rv = e_rv; v.e_rrdy = e_rrdy;
        v.ck_addr = ck; v.e_addr = ea;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs change and checks happen mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] A_IC = 32'h1FC0_0000;
    localparam logic [31:0] A_DC = 32'h0000_1000;
    localparam logic [31:0] A_UC = 32'hBFD0_0000;

    logic [2:0] exp_ord [4];

    initial begin
        // Master 2 = icache, 1 = dcache, 0 = uncache
        s_araddr = {A_IC, A_DC, A_UC};
        s_arlen  = {8'd3, 8'd3, 8'd0};
        s_arid   = {4'd4, 4'd5, 4'd6};
        s_arsize = {3'd2, 3'd2, 3'd2}; s_arburst = {2'd1, 2'd1, 2'd1};
        s_arcache = '0; s_arprot = '0;
        s_awaddr = {32'h0, 32'h0, 32'hBFD0_0010};
        s_awlen = '0; s_awid = {4'd0, 4'd1, 4'd2};
        s_awsize = {3'd2, 3'd2, 3'd2}; s_awburst = {2'd1, 2'd1, 2'd1};
        s_awcache = '0; s_awprot = '0;
        s_wdata = {32'h0, 32'h0, 32'hDEAD_BEEF};
        s_wstrb = {4'h0, 4'h0, 4'h3};
        s_wlast = 3'b001;
        m_rid = 4'h5; m_rdata = 32'hA5A5_0001; m_rresp = 2'b00; m_bid = 4'h2; m_bresp = 2'b00;

        // Reset with everything requesting: all handshakes must be held off
        s_arvalid = 3'b111; s_awvalid = 3'b111; s_wvalid = 3'b111;
        s_rready = 3'b111; s_bready = 3'b111;
        m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        m_rvalid = 1'b1; m_rlast = 1'b1; m_bvalid = 1'b1;
        #3;
        chk("reset_valids", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready},
            5'b0);
        chk("reset_upstream", {s_arready, s_rvalid, s_awready, s_wready, s_bvalid}, 15'b0);
        s_arvalid = '0; s_awvalid = '0; s_wvalid = '0;
        m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
        m_rvalid = 1'b0; m_rlast = 1'b0; m_bvalid = 1'b0;
        #4 resetn = 1'b1;
        step();

        // icache 4-beat read, then dcache/icache contention with a 5-cycle AR stall
        vq.push_back(mk(3'b100, 0, 0, 0, 3'b111, 0, 3'b000, 3'b000, 0, 0, 0));
        vq.push_back(mk(3'b100, 1, 0, 0, 3'b111, 1, 3'b100, 3'b000, 0, 1, A_IC));
        vq.push_back(mk(3'b000, 0, 1, 0, 3'b111, 0, 3'b000, 3'b100, 1, 0, 0));
        vq.push_back(mk(3'b000, 0, 1, 0, 3'b111, 0, 3'b000, 3'b100, 1, 0, 0));
        vq.push_back(mk(3'b000, 0, 1, 0, 3'b011, 0, 3'b000, 3'b100, 0, 0, 0));
        vq.push_back(mk(3'b000, 0, 1, 0, 3'b111, 0, 3'b000, 3'b100, 1, 0, 0));
        vq.push_back(mk(3'b000, 0, 1, 1, 3'b111, 0, 3'b000, 3'b100, 1, 0, 0));
        vq.push_back(mk(3'b000, 0, 0, 0, 3'b111, 0, 3'b000, 3'b000, 0, 0, 0));
        vq.push_back(mk(3'b110, 0, 0, 0, 3'b111, 0, 3'b000, 3'b000, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(3'b110, 0, 0, 0, 3'b111, 1, 3'b000, 3'b000, 0, 1, A_DC));
        vq.push_back(mk(3'b110, 1, 0, 0, 3'b111, 1, 3'b010, 3'b000, 0, 1, A_DC));
        vq.push_back(mk(3'b100, 0, 1, 1, 3'b111, 0, 3'b000, 3'b010, 1, 0, 0));
        vq.push_back(mk(3'b100, 0, 0, 0, 3'b111, 0, 3'b000, 3'b000, 0, 0, 0));
        vq.push_back(mk(3'b100, 1, 0, 0, 3'b111, 1, 3'b100, 3'b000, 0, 1, A_IC));
        vq.push_back(mk(3'b000, 0, 1, 1, 3'b111, 0, 3'b000, 3'b100, 1, 0, 0));
        vq.push_back(mk(3'b000, 0, 0, 0, 3'b111, 0, 3'b000, 3'b000, 0, 0, 0));

        foreach (vq[i]) begin
            s_arvalid = vq[i].arv; m_arready = vq[i].arrdy;
            m_rvalid = vq[i].rv; m_rlast = vq[i].rl; s_rready = vq[i].rrdy;
            #3;
            chk($sformatf("vec%0d", i), {m_arvalid, s_arready, s_rvalid, m_rready},
                {vq[i].e_arv, vq[i].e_arrdy, vq[i].e_rv, vq[i].e_rrdy});
            if (vq[i].ck_addr) chk($sformatf("vec%0d_addr", i), m_araddr, vq[i].e_addr);
            if (i == 1) begin
                chk("ic_arlen", m_arlen, 8'd3);
                chk("arlock", {m_arlock, m_awlock}, 4'b0);
            end
            if (i == 2) chk("rdata_bcast", s_rdata, 32'hA5A5_0001);
            step();
        end

        // All three requesting continuously
`ifdef AXI_ARB_ROUND_ROBIN_EN
        exp_ord[0] = 3'b001; exp_ord[1] = 3'b010; exp_ord[2] = 3'b100; exp_ord[3] = 3'b001;
`else
        exp_ord[0] = 3'b010; exp_ord[1] = 3'b010; exp_ord[2] = 3'b010; exp_ord[3] = 3'b010;
`endif
        for (int t = 0; t < 4; t++) begin
            s_arvalid = 3'b111; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
            #3 chk($sformatf("all_idle%0d", t), m_arvalid, 1'b0);
            step();
            m_arready = 1'b1;
            #3 chk($sformatf("all_grant%0d", t), s_arready, exp_ord[t]);
            step();
            m_arready = 1'b0; m_rvalid = 1'b1; m_rlast = 1'b1;
            #3 chk($sformatf("all_rvalid%0d", t), s_rvalid, exp_ord[t]);
            step();
        end
        s_arvalid = '0; m_rvalid = 1'b0; m_rlast = 1'b0;
        step();

        // uncache single-beat write alongside dcache 4-beat read
        s_arvalid = 3'b010; s_awvalid = 3'b001; s_wvalid = 3'b001;
        #3 chk("cc_idle", {m_arvalid, m_awvalid}, 2'b00);
        step();
        m_arready = 1'b1; m_awready = 1'b1;
        #3 chk("cc_addr", {m_arvalid, m_awvalid, s_arready, s_awready},
               {1'b1, 1'b1, 3'b010, 3'b001});
        step();
        s_arvalid = '0; s_awvalid = '0;
        m_arready = 1'b0; m_awready = 1'b0; m_wready = 1'b1; m_rvalid = 1'b1; m_rlast = 1'b0;
        #3 chk("cc_wbeat", {m_wvalid, m_wlast, s_wready, s_rvalid},
               {1'b1, 1'b1, 3'b001, 3'b010});
        chk("cc_wid", m_wid, 4'd2);
        chk("cc_wdata", {m_wdata, m_wstrb}, {32'hDEAD_BEEF, 4'h3});
        step();
        m_wready = 1'b0; s_wvalid = '0; m_bvalid = 1'b1;
        #3 chk("cc_bresp", {s_bvalid, m_bready, s_rvalid}, {3'b001, 1'b1, 3'b010});
        step();
        m_bvalid = 1'b0;
        #3 chk("cc_beat3", {s_bvalid, s_rvalid}, {3'b000, 3'b010});
        step();
        m_rlast = 1'b1;
        #3 chk("cc_last", s_rvalid, 3'b010);
        step();
        m_rvalid = 1'b0; m_rlast = 1'b0;
        #3 chk("cc_done", {m_rready, m_bready, m_wvalid}, 3'b000);

        // Reset in the middle of a dcache burst after two beats
        s_arvalid = 3'b010;
        step();
        m_arready = 1'b1;
        step();
        s_arvalid = '0; m_arready = 1'b0; m_rvalid = 1'b1;
        step();
        step();
        #1 resetn = 1'b0;
        #1 chk("rst_mid", {s_rvalid, m_rready, m_arvalid, s_arready}, 8'b0);
        step();
        resetn = 1'b1;
        #2 chk("rst_after", {s_rvalid, m_rready}, 4'b0);
        m_rvalid = 1'b0; s_arvalid = 3'b100;
        #1 chk("rst_req_idle", m_arvalid, 1'b0);
        step();
        #2 chk("rst_restart", {m_arvalid, m_araddr}, {1'b1, A_IC});
        s_arvalid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
